// File: rtl/core_launch_ctrl_if.sv
// ----------------------------------------------------------------------------
// core_launch_ctrl_if
//   Bundles the host job request, the per-core start/ready/done handshake,
//   the data-memory read port and the result stream of core_launch_ctrl.
//
//   master : the controller side (drives coreStart, memRdAddr, memMuxSel,
//            outData, outValid, busy, jobDone, timeout)
//   slave  : host / core array / memory / sink side
//
//   Signals:
//     go         job request
//     coreReady  per-core ready level
//     coreDone   per-core done level
//     coreStart  per-core start pulse
//     memRdAddr  data-memory read address
//     memRdData  data-memory read data (one cycle after the address)
//     memMuxSel  1 = controller owns the data-memory read port
//     outData    streamed result word
//     outValid   outData valid
//     outReady   sink accepts word
//     busy       controller not idle
//     jobDone    one-cycle pulse at job end
//     timeout    watchdog expired (sticky)
// ----------------------------------------------------------------------------
interface core_launch_ctrl_if #(
  parameter int N_CORES   = 4,
  parameter int REG_WIDTH = 12
);
  logic                 go;
  logic [N_CORES-1:0]   coreReady;
  logic [N_CORES-1:0]   coreDone;
  logic [N_CORES-1:0]   coreStart;
  logic [REG_WIDTH-1:0] memRdAddr;
  logic [REG_WIDTH-1:0] memRdData;
  logic                 memMuxSel;
  logic [REG_WIDTH-1:0] outData;
  logic                 outValid;
  logic                 outReady;
  logic                 busy;
  logic                 jobDone;
  logic                 timeout;

  modport master (
    input  go, coreReady, coreDone, memRdData, outReady,
    output coreStart, memRdAddr, memMuxSel, outData, outValid,
           busy, jobDone, timeout
  );

  modport slave (
    output go, coreReady, coreDone, memRdData, outReady,
    input  coreStart, memRdAddr, memMuxSel, outData, outValid,
           busy, jobDone, timeout
  );
endinterface

// File: rtl/core_launch_ctrl.sv
// ----------------------------------------------------------------------------
// core_launch_ctrl
//   System-side initiator for the cores' start/ready/done handshake. On a job
//   request it waits for all cores to be ready, starts them together, collects
//   their done flags, then takes over the data-memory read port and streams
//   DUMP_LEN words starting at DUMP_BASE over a valid/ready interface.
//
//   Ports:
//     clk   system clock
//     rstN  asynchronous active-low reset
//     bus   core_launch_ctrl_if.master (job request, core handshake,
//           data-memory read port, result stream, status)
//
//   Optional feature (macro CORE_WATCHDOG_EN):
//     defined   - a RUN-cycle watchdog of WDT_CYCLES cycles sets the sticky
//                 timeout flag, skips the dump and finishes the job.
//     undefined - no watchdog is built, timeout is constant 0 and RUN waits
//                 for all done flags indefinitely.
// ----------------------------------------------------------------------------
module core_launch_ctrl #(
  parameter int N_CORES    = 4,
  parameter int REG_WIDTH  = 12,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_LEN   = 16,
  parameter int WDT_CYCLES = 4095
) (
  input  logic                clk,
  input  logic                rstN,
  core_launch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_FINISH
  } state_t;

  localparam int CNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'((DUMP_LEN > 0) ? DUMP_LEN - 1 : 0);
  localparam logic [REG_WIDTH-1:0] BASE_ADDR = REG_WIDTH'(DUMP_BASE);

  state_t               state_q, state_d;
  logic [N_CORES-1:0]   done_seen_q, done_seen_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                 first_run_q, first_run_d;
  logic [N_CORES-1:0]   core_start_q, core_start_d;
  logic [REG_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic                 mem_mux_sel_q, mem_mux_sel_d;
  logic [REG_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 job_done_q, job_done_d;

  logic [N_CORES-1:0]   eff_done;
  logic [N_CORES-1:0]   done_acc;
  logic [CNT_W-1:0]     cnt_inc;

`ifdef CORE_WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Done levels left over from the previous job are still high during the
  // first RUN cycle, so they are ignored there.
  assign eff_done = first_run_q ? '0 : bus.coreDone;
  assign done_acc = done_seen_q | eff_done;
  assign cnt_inc  = word_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    done_seen_d   = done_seen_q;
    word_cnt_d    = word_cnt_q;
    first_run_d   = 1'b0;
    core_start_d  = '0;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_mux_sel_d = mem_mux_sel_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    busy_d        = busy_q;
    job_done_d    = 1'b0;
`ifdef CORE_WATCHDOG_EN
    wdt_cnt_d     = wdt_cnt_q;
    timeout_d     = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d     = S_LAUNCH;
          done_seen_d = '0;
          busy_d      = 1'b1;
`ifdef CORE_WATCHDOG_EN
          timeout_d   = 1'b0;
`endif
        end
      end

      S_LAUNCH: begin
        if (&bus.coreReady) begin
          state_d      = S_RUN;
          core_start_d = '1;
          first_run_d  = 1'b1;
`ifdef CORE_WATCHDOG_EN
          wdt_cnt_d    = '0;
`endif
        end
      end

      S_RUN: begin
        done_seen_d = done_acc;
        if (&done_acc) begin
          if (DUMP_LEN == 0) begin
            state_d    = S_FINISH;
            job_done_d = 1'b1;
          end else begin
            state_d       = S_DUMP_RD;
            word_cnt_d    = '0;
            mem_mux_sel_d = 1'b1;
            mem_rd_addr_d = BASE_ADDR;
          end
        end
`ifdef CORE_WATCHDOG_EN
        else if (wdt_cnt_q == WDT_LAST) begin
          state_d    = S_FINISH;
          timeout_d  = 1'b1;
          job_done_d = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
`endif
      end

      // Address is on the port this cycle; the memory returns data next cycle.
      S_DUMP_RD: begin
        state_d = S_DUMP_OUT;
      end

      // First DUMP_OUT cycle captures the read data; the word is then held
      // until the sink takes it.
      S_DUMP_OUT: begin
        if (!out_valid_q) begin
          out_data_d  = bus.memRdData;
          out_valid_d = 1'b1;
        end else if (bus.outReady) begin
          out_valid_d = 1'b0;
          if (word_cnt_q == LAST_CNT) begin
            state_d       = S_FINISH;
            mem_mux_sel_d = 1'b0;
            mem_rd_addr_d = '0;
            job_done_d    = 1'b1;
          end else begin
            state_d       = S_DUMP_RD;
            word_cnt_d    = cnt_inc;
            mem_rd_addr_d = BASE_ADDR + REG_WIDTH'(cnt_inc);
          end
        end
      end

      S_FINISH: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        word_cnt_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= S_IDLE;
      done_seen_q   <= '0;
      word_cnt_q    <= '0;
      first_run_q   <= 1'b0;
      core_start_q  <= '0;
      mem_rd_addr_q <= '0;
      mem_mux_sel_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
`ifdef CORE_WATCHDOG_EN
      wdt_cnt_q     <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      done_seen_q   <= done_seen_d;
      word_cnt_q    <= word_cnt_d;
      first_run_q   <= first_run_d;
      core_start_q  <= core_start_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_mux_sel_q <= mem_mux_sel_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      job_done_q    <= job_done_d;
`ifdef CORE_WATCHDOG_EN
      wdt_cnt_q     <= wdt_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign bus.coreStart = core_start_q;
  assign bus.memRdAddr = mem_rd_addr_q;
  assign bus.memMuxSel = mem_mux_sel_q;
  assign bus.outData   = out_data_q;
  assign bus.outValid  = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.jobDone   = job_done_q;

`ifdef CORE_WATCHDOG_EN
  assign bus.timeout   = timeout_q;
`else
  // WDT_CYCLES has no effect without the watchdog; this expression is
  // constant 0 and keeps the parameter referenced.
  assign bus.timeout   = (WDT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_core_launch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_core_launch_ctrl
//   Bench for core_launch_ctrl. dut_a dumps 4 words from 0xFFE (wrapping),
//   dut_b has DUMP_LEN=0 and a 20-cycle watchdog. Expected stream words are
//   queued when a dump is set up and popped as the sink accepts them.
// ----------------------------------------------------------------------------
module tb_core_launch_ctrl;
  localparam int NC = 4;
  localparam int RW = 12;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  core_launch_ctrl_if #(.N_CORES(NC), .REG_WIDTH(RW)) ifa ();
  core_launch_ctrl_if #(.N_CORES(NC), .REG_WIDTH(RW)) ifb ();

  core_launch_ctrl #(.N_CORES(NC), .REG_WIDTH(RW), .DUMP_BASE(12'hFFE),
                     .DUMP_LEN(4), .WDT_CYCLES(60))
    dut_a (.clk(clk), .rstN(rstN), .bus(ifa));

  core_launch_ctrl #(.N_CORES(NC), .REG_WIDTH(RW), .DUMP_BASE(0),
                     .DUMP_LEN(0), .WDT_CYCLES(20))
    dut_b (.clk(clk), .rstN(rstN), .bus(ifb));

  logic [RW-1:0] mem [0:4095];
  always @(posedge clk) begin
    ifa.memRdData <= mem[ifa.memRdAddr];
    ifb.memRdData <= mem[ifb.memRdAddr];
  end

  int checks = 0;
  int passes = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_addr_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump_words();
    logic [RW-1:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 12'hFFE + 12'(k);
      exp_addr_q.push_back(a);
      exp_q.push_back(a + 12'h100);
    end
  endtask

  task automatic test_reset();
    ifa.go = 0; ifa.coreReady = '0; ifa.coreDone = '0; ifa.outReady = 0;
    ifb.go = 0; ifb.coreReady = '0; ifb.coreDone = '0; ifb.outReady = 0;
    rstN = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifa.coreStart !== 4'h0) $display("FAIL reset_coreStart got %h want 0", ifa.coreStart); else passes++;
    checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ifa.busy); else passes++;
    checks++; if (ifa.memMuxSel !== 1'b0) $display("FAIL reset_memMuxSel got %b want 0", ifa.memMuxSel); else passes++;
    checks++; if (ifa.outValid !== 1'b0) $display("FAIL reset_outValid got %b want 0", ifa.outValid); else passes++;
    checks++; if (ifa.outData !== 12'h0) $display("FAIL reset_outData got %h want 0", ifa.outData); else passes++;
    checks++; if (ifa.jobDone !== 1'b0) $display("FAIL reset_jobDone got %b want 0", ifa.jobDone); else passes++;
    checks++; if (ifa.timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", ifa.timeout); else passes++;
    checks++; if (ifb.busy !== 1'b0) $display("FAIL reset_busy_b got %b want 0", ifb.busy); else passes++;
    rstN = 1;
    step();
  endtask

  task automatic test_launch();
    ifa.coreReady = '1;
    ifa.go = 1;
    step();
    ifa.go = 0;
    checks++; if (ifa.busy !== 1'b1) $display("FAIL launch_busy got %b want 1", ifa.busy); else passes++;
    checks++; if (ifa.coreStart !== 4'h0) $display("FAIL launch_early_start got %h want 0", ifa.coreStart); else passes++;
    step();
    checks++; if (ifa.coreStart !== 4'hF) $display("FAIL launch_start got %h want f", ifa.coreStart); else passes++;
    // stale done levels during the first RUN cycle must be ignored
    ifa.coreDone = '1;
    step();
    ifa.coreDone = '0;
    checks++; if (ifa.coreStart !== 4'h0) $display("FAIL launch_start_width got %h want 0", ifa.coreStart); else passes++;
    checks++; if (ifa.memMuxSel !== 1'b0) $display("FAIL stale_done_mask got %b want 0", ifa.memMuxSel); else passes++;
    step();
    checks++; if (ifa.busy !== 1'b1 || ifa.memMuxSel !== 1'b0) $display("FAIL run_wait busy=%b mux=%b want 1/0", ifa.busy, ifa.memMuxSel); else passes++;
  endtask

  task automatic test_staggered_done();
    logic early = 0;
    for (int i = 0; i < 40; i++) begin
      ifa.coreDone = (i == 10) ? 4'b0001 : (i == 39) ? 4'b1110 : 4'b0000;
      step();
      if (i < 39 && ifa.memMuxSel !== 1'b0) early = 1;
    end
    ifa.coreDone = '0;
    checks++; if (early !== 1'b0) $display("FAIL stagger_early_dump got %b want 0", early); else passes++;
    checks++; if (ifa.memMuxSel !== 1'b1) $display("FAIL stagger_dump_start got %b want 1", ifa.memMuxSel); else passes++;
    checks++; if (ifa.memRdAddr !== 12'hFFE) $display("FAIL stagger_first_addr got %h want ffe", ifa.memRdAddr); else passes++;
  endtask

  task automatic test_dump_backpressure();
    int jd = 0;
    logic hold_chk = 0;
    logic [RW-1:0] held = '0;
    logic [RW-1:0] e, ea;
    push_dump_words();
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ifa.jobDone === 1'b1) jd++;
      if (hold_chk) begin
        checks++;
        if (ifa.outValid !== 1'b1 || ifa.outData !== held)
          $display("FAIL dump_hold got valid=%b data=%h want 1/%h", ifa.outValid, ifa.outData, held);
        else passes++;
        hold_chk = 0;
      end
      ifa.outReady = (cyc % 2 == 0);
      if (ifa.outValid === 1'b1) begin
        if (ifa.outReady) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL dump_extra_word got %h want none", ifa.outData);
          end else begin
            e  = exp_q.pop_front();
            ea = exp_addr_q.pop_front();
            checks++; if (ifa.outData !== e) $display("FAIL dump_data got %h want %h", ifa.outData, e); else passes++;
            checks++; if (ifa.memRdAddr !== ea) $display("FAIL dump_addr got %h want %h", ifa.memRdAddr, ea); else passes++;
            checks++; if (ifa.memMuxSel !== 1'b1) $display("FAIL dump_mux got %b want 1", ifa.memMuxSel); else passes++;
          end
        end else begin
          hold_chk = 1;
          held     = ifa.outData;
        end
      end
      step();
    end
    ifa.outReady = 0;
    checks++; if (exp_q.size() != 0) $display("FAIL dump_missing_words got %0d left want 0", exp_q.size()); else passes++;
    checks++; if (jd != 1) $display("FAIL dump_jobDone_count got %0d want 1", jd); else passes++;
    checks++; if (ifa.busy !== 1'b0 || ifa.memMuxSel !== 1'b0) $display("FAIL dump_end busy=%b mux=%b want 0/0", ifa.busy, ifa.memMuxSel); else passes++;
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic test_ready_wait();
    logic stray = 0;
    ifa.coreReady = 4'b1011;
    ifa.go = 1;
    step();
    ifa.go = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifa.coreStart !== 4'h0) stray = 1;
      step();
    end
    checks++; if (stray !== 1'b0) $display("FAIL ready_wait_start got %b want 0", stray); else passes++;
    checks++; if (ifa.busy !== 1'b1) $display("FAIL ready_wait_busy got %b want 1", ifa.busy); else passes++;
    ifa.coreReady = 4'b1111;
    step();
    checks++; if (ifa.coreStart !== 4'hF) $display("FAIL ready_wait_pulse got %h want f", ifa.coreStart); else passes++;
    step();
    checks++; if (ifa.coreStart !== 4'h0) $display("FAIL ready_wait_pulse_end got %h want 0", ifa.coreStart); else passes++;
  endtask

  task automatic test_back_to_back();
    int jd = 0;
    int last_acc = -10;
    logic fast = 0;
    logic [RW-1:0] e;
    ifa.coreDone = '1;
    step();
    ifa.coreDone = '0;
    push_dump_words();
    ifa.outReady = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ifa.jobDone === 1'b1) jd++;
      if (ifa.outValid === 1'b1) begin
        if (cyc - last_acc < 2) fast = 1;
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL b2b_extra_word got %h want none", ifa.outData);
        end else begin
          e = exp_q.pop_front();
          void'(exp_addr_q.pop_front());
          checks++; if (ifa.outData !== e) $display("FAIL b2b_data got %h want %h", ifa.outData, e); else passes++;
        end
      end
      step();
    end
    ifa.outReady = 0;
    checks++; if (exp_q.size() != 0) $display("FAIL b2b_missing_words got %0d left want 0", exp_q.size()); else passes++;
    checks++; if (fast !== 1'b0) $display("FAIL b2b_rate got %b want 0", fast); else passes++;
    checks++; if (jd != 1) $display("FAIL b2b_jobDone_count got %0d want 1", jd); else passes++;
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic test_len0();
    int jd = 0, starts = 0;
    logic ov = 0, mux = 0;
    ifb.coreReady = '1;
    for (int c = 0; c < 16; c++) begin
      if (ifb.jobDone === 1'b1) jd++;
      if (ifb.coreStart === 4'hF) starts++;
      if (ifb.outValid !== 1'b0) ov = 1;
      if (ifb.memMuxSel !== 1'b0) mux = 1;
      ifb.go       = (c <= 4);
      ifb.coreDone = (c >= 2 && c <= 4) ? 4'hF : 4'h0;
      step();
    end
    ifb.go = 0;
    ifb.coreDone = '0;
    checks++; if (jd != 1) $display("FAIL len0_jobDone_count got %0d want 1", jd); else passes++;
    checks++; if (starts != 1) $display("FAIL len0_start_count got %0d want 1", starts); else passes++;
    checks++; if (ov !== 1'b0) $display("FAIL len0_outValid got %b want 0", ov); else passes++;
    checks++; if (mux !== 1'b0) $display("FAIL len0_memMuxSel got %b want 0", mux); else passes++;
    checks++; if (ifb.busy !== 1'b0) $display("FAIL len0_busy_end got %b want 0", ifb.busy); else passes++;
  endtask

  task automatic test_async_reset();
    int n = 0;
    ifa.coreReady = '1;
    ifa.outReady  = 0;
    ifa.go = 1;
    step();
    ifa.go = 0;
    step();
    ifa.coreDone = '1;
    step();
    step();
    ifa.coreDone = '0;
    while (ifa.outValid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (ifa.outValid !== 1'b1) $display("FAIL areset_reach_dump got %b want 1", ifa.outValid); else passes++;
    #2;
    rstN = 0;
    #1;
    checks++; if (ifa.outValid !== 1'b0) $display("FAIL areset_outValid got %b want 0", ifa.outValid); else passes++;
    checks++; if (ifa.memMuxSel !== 1'b0) $display("FAIL areset_memMuxSel got %b want 0", ifa.memMuxSel); else passes++;
    checks++; if (ifa.busy !== 1'b0) $display("FAIL areset_busy got %b want 0", ifa.busy); else passes++;
    checks++; if (ifa.outData !== 12'h0) $display("FAIL areset_outData got %h want 0", ifa.outData); else passes++;
    checks++; if (ifa.memRdAddr !== 12'h0) $display("FAIL areset_memRdAddr got %h want 0", ifa.memRdAddr); else passes++;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1;
    step();
  endtask

  task automatic test_watchdog();
    int jd = 0;
    logic ov = 0;
    ifb.coreReady = '1;
    ifb.go = 1;
    step();
    ifb.go = 0;
    ifb.coreDone = 4'b0111;
    for (int c = 0; c < 40; c++) begin
      if (ifb.jobDone === 1'b1) jd++;
      if (ifb.outValid !== 1'b0) ov = 1;
      step();
    end
    checks++; if (ov !== 1'b0) $display("FAIL wdt_outValid got %b want 0", ov); else passes++;
`ifdef CORE_WATCHDOG_EN
    checks++; if (ifb.timeout !== 1'b1) $display("FAIL wdt_timeout got %b want 1", ifb.timeout); else passes++;
    checks++; if (jd != 1) $display("FAIL wdt_jobDone_count got %0d want 1", jd); else passes++;
    checks++; if (ifb.busy !== 1'b0) $display("FAIL wdt_busy got %b want 0", ifb.busy); else passes++;
    ifb.go = 1;
    step();
    ifb.go = 0;
    checks++; if (ifb.timeout !== 1'b0) $display("FAIL wdt_clear_on_go got %b want 0", ifb.timeout); else passes++;
`else
    checks++; if (ifb.timeout !== 1'b0) $display("FAIL wdt_timeout_tied got %b want 0", ifb.timeout); else passes++;
    checks++; if (jd != 0) $display("FAIL wdt_jobDone_count got %0d want 0", jd); else passes++;
    checks++; if (ifb.busy !== 1'b1) $display("FAIL wdt_run_waits got %b want 1", ifb.busy); else passes++;
`endif
    ifb.coreDone = '0;
    rstN = 0;
    #1;
    checks++; if (ifb.busy !== 1'b0) $display("FAIL wdt_reset_busy got %b want 0", ifb.busy); else passes++;
    step();
    rstN = 1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'(i) + 12'h100;
    test_reset();
    test_launch();
    test_staggered_done();
    test_dump_backpressure();
    test_ready_wait();
    test_back_to_back();
    test_len0();
    test_async_reset();
    test_watchdog();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/core_launch_ctrl.md
Name: core_launch_ctrl

Overview:
System-side initiator for the cores' start/ready/done handshake, and reader of their shared data memory. On a job request it waits until every core reports ready, then launches all cores together and collects their done flags. Once all cores have finished, it takes over the data-memory read port and streams a fixed result window out over a valid/ready interface. It sits at top level between the host and the processor array.

Parameters:
N_CORES, 4, number of processor cores controlled
REG_WIDTH, 12, data word and data-memory address width
DUMP_BASE, 0, first data-memory address streamed out after a job
DUMP_LEN, 16, number of words streamed out (0 allowed)
WDT_CYCLES, 4095, watchdog limit in RUN cycles (used only with CORE_WATCHDOG_EN)

Ports:
clk  in  1  system clock
rstN  in  1  reset, asynchronous, active-low
go  in  1  job request; sampled only in IDLE
coreReady  in  N_CORES  per-core ready level
coreDone  in  N_CORES  per-core done level
coreStart  out  N_CORES  per-core start pulse
memRdAddr  out  REG_WIDTH  data-memory read address
memRdData  in  REG_WIDTH  data-memory read data, valid 1 cycle after address
memMuxSel  out  1  1 = controller owns data-memory read port
outData  out  REG_WIDTH  streamed result word
outValid  out  1  outData valid
outReady  in  1  sink accepts word
busy  out  1  high in any state except IDLE
jobDone  out  1  1-cycle pulse at job end
timeout  out  1  watchdog expired (sticky)

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset, including mid-job: all outputs 0, FSM to IDLE, doneSeen cleared, counters 0. The reset state is entered immediately and is independent of clk.
- FSM states: IDLE, LAUNCH, RUN, DUMP_RD, DUMP_OUT, FINISH.
- IDLE: if go=1, clear doneSeen and move to LAUNCH. In all other states go is ignored.
- LAUNCH: stay until coreReady is all ones. In that cycle coreStart is driven to all ones, registered, for exactly 1 cycle, and the FSM moves to RUN. coreStart is 0 in every other cycle.
- RUN:
  - doneSeen |= coreDone every cycle. doneSeen bits are sticky.
  - Done levels that are still stale from the previous job are masked: coreDone is ignored in the first RUN cycle.
  - When (doneSeen | coreDone) is all ones, move to DUMP_RD with wordCnt=0. If DUMP_LEN=0, move to FINISH instead.
- DUMP_RD:
  - memMuxSel=1.
  - memRdAddr = DUMP_BASE + wordCnt, truncated to REG_WIDTH (wraps mod 2^REG_WIDTH).
  - Next state DUMP_OUT.
- DUMP_OUT:
  - memMuxSel=1 and memRdAddr held.
  - On entry, memRdData is captured into outData and outValid=1.
  - outData and outValid stay stable while outReady=0.
  - On outValid && outReady: wordCnt++. If wordCnt reaches DUMP_LEN-1 before the increment, move to FINISH; otherwise move to DUMP_RD.
  - Throughput is at most 1 word per 2 cycles.
- FINISH: jobDone=1 for 1 cycle, memMuxSel=0, outValid=0, then IDLE.
- memMuxSel is 0 outside the DUMP states. Cores own the port then.
- busy is high in LAUNCH through FINISH inclusive.

Optional Feature:
CORE_WATCHDOG_EN
- Defined:
  - A RUN-cycle counter clears on entry to RUN.
  - When it reaches WDT_CYCLES without all done bits set, timeout is set, the dump is skipped, and the FSM goes to FINISH (jobDone still pulses).
  - timeout stays high until the next accepted go or reset.
- Undefined: no counter is built, timeout is tied 0, and RUN waits indefinitely.

Test Plan:
1. Reset with rstN=0, then N_CORES=4 and all cores ready. Pulse go -> busy=1 next cycle; coreStart=4'b1111 for exactly 1 cycle; FSM in RUN.
2. coreReady=4'b1011 when go arrives -> no start; raise bit 2 five cycles later -> coreStart pulses on the cycle all ready is seen.
3. Done arrives staggered (core0 at cycle 10, cores 1–3 at cycle 40; each done level dropped after 1 cycle) -> DUMP begins only after cycle 40.
4. Memory preloaded with value = addr + 0x100, DUMP_BASE=0xFFE, DUMP_LEN=4, outReady toggling 1/0 -> outData sequence 0x0FE, 0x0FF, 0x100, 0x101 (addresses wrap to 0x000); outData held while outReady=0; jobDone pulses once.
5. DUMP_LEN=0 -> after all done, jobDone pulses with no outValid; go asserted during RUN has no effect.
6. rstN pulled low in DUMP_OUT with outValid=1 -> outputs 0 asynchronously. With CORE_WATCHDOG_EN and WDT_CYCLES=20 and core3 never done -> timeout=1 and jobDone pulse, no outValid.
